// File: rtl/adder_tree_chunk_sequencer_if.sv
// adder_tree_chunk_sequencer_if: operand-source, adder-tree and shared FP adder handshake for the chunk sequencer
interface adder_tree_chunk_sequencer_if #(parameter int CW = 8);
  logic op_start, op_busy, chunk_req, chunk_valid, tree_start, tree_finish;
  logic acc_start, acc_finish, result_valid, op_err;
  logic [CW-1:0] chunk_idx;
  logic [31:0] tree_sum, acc_a, acc_b, acc_sum, result;
  modport master (
    input  op_start, chunk_valid, tree_finish, tree_sum, acc_finish, acc_sum,
    output op_busy, chunk_req, chunk_idx, tree_start, acc_start, acc_a, acc_b, result, result_valid, op_err
  );
  modport slave (
    output op_start, chunk_valid, tree_finish, tree_sum, acc_finish, acc_sum,
    input  op_busy, chunk_req, chunk_idx, tree_start, acc_start, acc_a, acc_b, result, result_valid, op_err
  );
endinterface

// File: rtl/adder_tree_chunk_sequencer.sv
// adder_tree_chunk_sequencer: runs one adder tree over NCHUNK chunks and folds the partial sums
// through a shared two-input FP adder, strictly in chunk order; values pass through bit-exact.
module adder_tree_chunk_sequencer #(
  parameter int NI     = 128,
  parameter int NCHUNK = 2,
  parameter int CW     = 8,
  parameter int TMO    = 1024
) (
  input logic clk,
  input logic rst_n,
  adder_tree_chunk_sequencer_if.master bus
);
  localparam int TW = $clog2(TMO) + 1;
  typedef enum logic [2:0] {IDLE, REQ, FIRE, WAIT_T, ACC, WAIT_A, DONE} state_t;
  state_t state;
  logic [TW-1:0] wdog;
  logic [31:0] total;
  logic last, tmo;
  if (NI < 1 || NCHUNK < 1 || (2 ** CW) < NCHUNK || TMO < 1) begin : g_param_check
    $error("adder_tree_chunk_sequencer: illegal parameter combination");
  end
  assign last = bus.chunk_idx == CW'(NCHUNK - 1);
  assign tmo  = wdog == TW'(TMO - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wdog             <= '0;
      total            <= '0;
      bus.op_busy      <= 1'b0;
      bus.chunk_req    <= 1'b0;
      bus.chunk_idx    <= '0;
      bus.tree_start   <= 1'b0;
      bus.acc_start    <= 1'b0;
      bus.acc_a        <= '0;
      bus.acc_b        <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.op_err       <= 1'b0;
    end else begin
      bus.tree_start   <= 1'b0;
      bus.acc_start    <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.op_err       <= 1'b0;
      case (state)
        IDLE:
          // op_busy may still be high for the op_err cycle; a start then is ignored
          if (bus.op_start && !bus.op_busy) begin
            state         <= REQ;
            bus.op_busy   <= 1'b1;
            bus.chunk_req <= 1'b1;
            bus.chunk_idx <= '0;
          end else bus.op_busy <= 1'b0;
        REQ:
          if (bus.chunk_valid) begin
            state          <= FIRE;
            bus.chunk_req  <= 1'b0;
            bus.tree_start <= 1'b1;
          end
        FIRE: begin
          state <= WAIT_T;
          wdog  <= '0;
        end
        WAIT_T:
          if (bus.tree_finish) begin
            if (bus.chunk_idx == '0) begin
              total <= bus.tree_sum;
              if (last) begin
                state            <= DONE;
                bus.result       <= bus.tree_sum;
                bus.result_valid <= 1'b1;
              end else begin
                state         <= REQ;
                bus.chunk_req <= 1'b1;
                bus.chunk_idx <= bus.chunk_idx + 1'b1;
              end
            end else begin
              state         <= ACC;
              bus.acc_start <= 1'b1;
              bus.acc_a     <= total;
              bus.acc_b     <= bus.tree_sum;
            end
          end else if (tmo) begin
            state      <= IDLE;
            bus.op_err <= 1'b1;
          end else wdog <= wdog + 1'b1;
        ACC: begin
          state <= WAIT_A;
          wdog  <= '0;
        end
        WAIT_A:
          if (bus.acc_finish) begin
            total <= bus.acc_sum;
            if (last) begin
              state            <= DONE;
              bus.result       <= bus.acc_sum;
              bus.result_valid <= 1'b1;
            end else begin
              state         <= REQ;
              bus.chunk_req <= 1'b1;
              bus.chunk_idx <= bus.chunk_idx + 1'b1;
            end
          end else if (tmo) begin
            state      <= IDLE;
            bus.op_err <= 1'b1;
          end else wdog <= wdog + 1'b1;
        DONE: begin
          state       <= IDLE;
          bus.op_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_chunk_sequencer.sv
// tb_adder_tree_chunk_sequencer: directed stimulus with a queue scoreboard; dut2 runs two chunks,
// dut1 a single chunk, both with a 16-cycle watchdog.
module tb_adder_tree_chunk_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_hold = 1'b0;
  int total = 0, bad = 0, ts_cnt = 0, rv_cnt = 0, acc1_cnt = 0, err_cnt = 0;
  logic [31:0] exp_res[$], exp_res1[$], acc_resp[$];
  logic [63:0] exp_acc[$];
  always #5 clk = ~clk;
  adder_tree_chunk_sequencer_if #(.CW(8)) b2 ();
  adder_tree_chunk_sequencer_if #(.CW(8)) b1 ();
  adder_tree_chunk_sequencer #(.NI(128), .NCHUNK(2), .CW(8), .TMO(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  adder_tree_chunk_sequencer #(.NI(128), .NCHUNK(1), .CW(8), .TMO(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b2.result_valid) begin
      rv_cnt++;
      if (exp_res.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_result: got %0h expected no result", b2.result);
      end else chk("dut2_result", b2.result, exp_res.pop_front());
    end
    if (b2.acc_start) begin
      if (exp_acc.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_acc_ops: got %0h_%0h expected no acc_start", b2.acc_a, b2.acc_b);
      end else chk("dut2_acc_ops", {b2.acc_a, b2.acc_b}, exp_acc.pop_front());
    end
    if (b2.tree_start) ts_cnt++;
    if (b2.op_err) err_cnt++;
    if (b1.acc_start) acc1_cnt++;
    if (b1.result_valid) begin
      if (exp_res1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_result: got %0h expected no result", b1.result);
      end else chk("dut1_result", b1.result, exp_res1.pop_front());
    end
  end

  // three-cycle model of the shared FP adder; sums come from the stimulus table
  initial begin
    b2.acc_finish = 1'b0;
    b2.acc_sum = '0;
    forever begin
      @(negedge clk);
      if (b2.acc_start && !acc_hold && rst_n) begin
        repeat (3) @(negedge clk);
        b2.acc_sum = acc_resp.size() != 0 ? acc_resp.pop_front() : 32'hDEAD_DEAD;
        b2.acc_finish = 1'b1;
        @(negedge clk);
        b2.acc_finish = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic pulse_start2();
    b2.op_start = 1'b1;
    @(negedge clk);
    b2.op_start = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 50 && !b2.chunk_req; n++) @(negedge clk);
    chk("req_wait", b2.chunk_req, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && b2.op_busy; n++) @(negedge clk);
    chk("idle_wait", b2.op_busy, 0);
  endtask

  // td < 0 withholds tree_finish
  task automatic run_chunk(input logic [31:0] s, input int vd, input int td);
    int hi = 0;
    wait_req();
    repeat (vd) begin
      @(negedge clk);
      hi += int'(b2.chunk_req);
    end
    chk("req_held", hi, vd);
    b2.chunk_valid = 1'b1;
    @(negedge clk);
    chk("tree_start_on", b2.tree_start, 1);
    chk("req_drop", b2.chunk_req, 0);
    b2.chunk_valid = 1'b0;
    @(negedge clk);
    chk("tree_start_off", b2.tree_start, 0);
    if (td >= 0) begin
      repeat (td) @(negedge clk);
      b2.tree_sum = s;
      b2.tree_finish = 1'b1;
      @(negedge clk);
      b2.tree_finish = 1'b0;
    end
  endtask

  initial begin
    int rv0, ts0, e0, k;
    b2.op_start = 0; b2.chunk_valid = 0; b2.tree_finish = 0; b2.tree_sum = '0;
    b1.op_start = 0; b1.chunk_valid = 0; b1.tree_finish = 0; b1.tree_sum = '0;
    b1.acc_finish = 0; b1.acc_sum = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl2", {b2.op_busy, b2.chunk_req, b2.tree_start, b2.acc_start, b2.result_valid, b2.op_err}, 0);
    chk("rst_data2", {b2.result, b2.acc_a}, 0);
    chk("rst_idx2", {b2.chunk_idx, b2.acc_b}, 0);
    chk("rst_ctl1", {b1.op_busy, b1.chunk_req, b1.result_valid, b1.op_err, b1.result}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two chunks: 1.0 + 2.0
    exp_acc.push_back({32'h3F80_0000, 32'h4000_0000});
    acc_resp.push_back(32'h4040_0000);
    exp_res.push_back(32'h4040_0000);
    rv0 = rv_cnt;
    pulse_start2();
    chk("start_to_req", b2.chunk_req, 1);
    chk("start_busy", b2.op_busy, 1);
    chk("first_idx", b2.chunk_idx, 0);
    run_chunk(32'h3F80_0000, 0, 0);
    wait_req();
    chk("second_idx", b2.chunk_idx, 1);
    run_chunk(32'h4000_0000, 0, 0);
    wait_idle();
    chk("one_pulse", rv_cnt - rv0, 1);
    chk("result_held", b2.result, 32'h4040_0000);

    // single chunk: no accumulation, busy drops one cycle after the pulse
    exp_res1.push_back(32'hC0A0_0000);
    b1.op_start = 1'b1;
    @(negedge clk);
    b1.op_start = 1'b0;
    for (int n = 0; n < 50 && !b1.chunk_req; n++) @(negedge clk);
    chk("d1_req", b1.chunk_req, 1);
    b1.chunk_valid = 1'b1;
    @(negedge clk);
    b1.chunk_valid = 1'b0;
    @(negedge clk);
    b1.tree_sum = 32'hC0A0_0000;
    b1.tree_finish = 1'b1;
    @(negedge clk);
    b1.tree_finish = 1'b0;
    chk("d1_rv_on", b1.result_valid, 1);
    chk("d1_busy_in_pulse", b1.op_busy, 1);
    @(negedge clk);
    chk("d1_rv_off", b1.result_valid, 0);
    chk("d1_busy_off", b1.op_busy, 0);

    // repeated op_start while busy and a stray tree_finish in REQ are ignored
    exp_acc.push_back({32'h4040_0000, 32'h3F80_0000});
    acc_resp.push_back(32'h4080_0000);
    exp_res.push_back(32'h4080_0000);
    ts0 = ts_cnt;
    rv0 = rv_cnt;
    pulse_start2();
    b2.tree_sum = 32'hDEAD_BEEF;
    b2.tree_finish = 1'b1;
    b2.op_start = 1'b1;
    @(negedge clk);
    b2.tree_finish = 1'b0;
    b2.op_start = 1'b0;
    run_chunk(32'h4040_0000, 0, 0);
    pulse_start2();
    run_chunk(32'h3F80_0000, 2, 0);
    wait_idle();
    chk("tree_starts", ts_cnt - ts0, 2);
    chk("stray_one_pulse", rv_cnt - rv0, 1);
    repeat (5) @(negedge clk);
    chk("no_requeue", b2.op_busy, 0);

    // watchdog on a withheld tree_finish
    e0 = err_cnt;
    rv0 = rv_cnt;
    pulse_start2();
    run_chunk(32'h0, 0, -1);
    k = 0;
    while (!b2.op_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", k, 16);
    chk("err_busy", b2.op_busy, 1);
    chk("err_result_kept", b2.result, 32'h4080_0000);
    @(negedge clk);
    chk("err_pulse_off", b2.op_err, 0);
    chk("err_idle", b2.op_busy, 0);
    chk("err_count", err_cnt - e0, 1);
    chk("err_no_result", rv_cnt - rv0, 0);
    exp_acc.push_back({32'h4040_0000, 32'h4040_0000});
    acc_resp.push_back(32'h40C0_0000);
    exp_res.push_back(32'h40C0_0000);
    pulse_start2();
    run_chunk(32'h4040_0000, 0, 0);
    run_chunk(32'h4040_0000, 0, 1);
    wait_idle();

    // asynchronous reset while waiting on the FP adder
    acc_hold = 1'b1;
    exp_acc.push_back({32'h3F80_0000, 32'h4000_0000});
    pulse_start2();
    run_chunk(32'h3F80_0000, 0, 0);
    run_chunk(32'h4000_0000, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {b2.op_busy, b2.chunk_req, b2.tree_start, b2.acc_start, b2.result_valid, b2.op_err}, 0);
    chk("arst_idx", b2.chunk_idx, 0);
    chk("arst_acc", {b2.acc_a, b2.acc_b}, 0);
    chk("arst_result", b2.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_hold = 1'b0;
    @(negedge clk);
    exp_acc.push_back({32'h3F80_0000, 32'h3F80_0000});
    acc_resp.push_back(32'h4000_0000);
    exp_res.push_back(32'h4000_0000);
    pulse_start2();
    run_chunk(32'h3F80_0000, 0, 0);
    run_chunk(32'h3F80_0000, 0, 0);
    wait_idle();

    // delayed chunk_valid holds the request
    exp_acc.push_back({32'h3F80_0000, 32'hBF80_0000});
    acc_resp.push_back(32'h0000_0000);
    exp_res.push_back(32'h0000_0000);
    pulse_start2();
    run_chunk(32'h3F80_0000, 10, 0);
    run_chunk(32'hBF80_0000, 0, 3);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("res_queue_empty", exp_res.size(), 0);
    chk("acc_queue_empty", exp_acc.size(), 0);
    chk("d1_queue_empty", exp_res1.size(), 0);
    chk("d1_no_acc", acc1_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
